vga_frame_decoder: RTL and testbench
====================================

# vga_frame_decoder

Receive-side counterpart of the VGA timing generator. It samples the sync and colour lines the game drives (`vga_h_sync`, `vga_v_sync`, `vga_R/G/B`) on a per-pixel strobe, measures line and frame geometry, and locks onto the incoming timing. Once locked it recovers the pixel coordinates and reports a per-frame count of lit pixels. It is used as an in-fabric self-check of the display path and as the capture front-end for a future frame-grab block.

## Interface

Parameters:
- `H_ACTIVE`, 640: active pixels per line.
- `V_ACTIVE`, 480: active lines per frame.
- `H_START`, 32: pixel strobes from the h-sync pulse end (rising edge of `vga_h_sync`) to the first active pixel.
- `V_START`, 11: lines from the first line after the v-sync pulse end to the first active line.

Ports:
- `clk`, in, 1: system clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `pix_en`, in, 1: one-`clk` strobe per pixel. All sampling and counting happens only on cycles where it is high.
- `vga_h_sync`, in, 1: horizontal sync, active low.
- `vga_v_sync`, in, 1: vertical sync, active low.
- `vga_R`, `vga_G`, `vga_B`, in, 1 each: colour inputs.
- `pix_valid`, out, 1: registered; high for one `clk` when the sampled pixel is active and `locked`=1.
- `pix_x`, out, 10: recovered column, 0..H_ACTIVE-1.
- `pix_y`, out, 9: recovered row, 0..V_ACTIVE-1.
- `pix_rgb`, out, 3: sampled {R,G,B}.
- `line_len`, out, 11: last measured line length in strobes.
- `frame_lines`, out, 10: last measured line count per frame.
- `locked`, out, 1: timing is stable.
- `frame_done`, out, 1: one-`clk` pulse at each frame boundary while locked.
- `lit_count`, out, 19: count of active pixels with any colour bit set in the last completed frame.

## Operation

- **Sampling and edge detection.** On each `pix_en`, register the sync inputs and detect rising edges:
  - HSE is a `vga_h_sync` 0→1 transition.
  - VSE is a `vga_v_sync` 0→1 transition.
- **Horizontal counter `hcnt`** (11 bits):
  - On HSE: `line_len` ← `hcnt`+1, then `hcnt` ← 0.
  - Otherwise `hcnt` increments and saturates at 2047.
  - Saturation forces the state to UNLOCKED.
- **Vertical counter `vcnt`** (10 bits):
  - A VSE sets `vpend`.
  - On the next HSE with `vpend`=1 (the frame boundary FB): `frame_lines` ← `vcnt`+1, then `vcnt` ← 0 and `vpend` is cleared.
  - Any other HSE increments `vcnt`, saturating at 1023.
  - VSE and HSE on the same strobe: `vpend` is set and FB is taken on that same strobe.
- **Active region.** Active when H_START ≤ `hcnt` < H_START+H_ACTIVE and V_START ≤ `vcnt` < V_START+V_ACTIVE.
  - `pix_x` = `hcnt`−H_START.
  - `pix_y` = `vcnt`−V_START.
- **Lit-pixel accumulator** (19 bits): increments on active strobes where R|G|B = 1. At FB it is copied to `lit_count` and cleared. Accumulation runs regardless of lock state.
- **Lock FSM** (states UNLOCKED, ACQUIRE, LOCKED), evaluated at each FB:
  - UNLOCKED → ACQUIRE: save the current `line_len` and `frame_lines` as reference values.
  - ACQUIRE → LOCKED: if both measurements equal the reference; otherwise reload the reference and stay in ACQUIRE.
  - LOCKED → UNLOCKED: if either measurement differs from the reference.
  - LOCKED: `line_len` differing from the reference at any HSE also forces UNLOCKED immediately, without waiting for FB.
  - `hcnt` saturation forces UNLOCKED from any state.
- **`locked`** = (state == LOCKED).
- **`frame_done`** pulses only on an FB that leaves the FSM in LOCKED.

## Timing

- **Reset values.** All outputs are 0. Internal state: counters 0, `vpend` 0, FSM in UNLOCKED, sync sample registers 1 (idle).
- **Latency.** `pix_valid`, `pix_x`, `pix_y`, and `pix_rgb` update on the `clk` edge that samples `pix_en`=1, so they are valid one cycle later. `pix_valid` falls on the next `clk`.
- **Measurements.** `line_len`, `frame_lines`, `lit_count`, `locked`, and `frame_done` all update on the same edge as the HSE/FB that triggers them.
- **Gaps.** With no `pix_en`, all state holds and `pix_valid`=0.
- **Mid-frame reset.** Reset clears everything. First lock is declared at the 3rd FB after reset: the 1st FB enters ACQUIRE, the 2nd FB compares a partial-frame measurement (may fail), and the 3rd FB locks.

## Test plan

- **Nominal lock.** Stimulus: `pix_en` every 4th `clk`; 768 strobes/line with h-sync low at `hcnt` 720–735 of the generator; 512 lines with v-sync low on line 500. Required: `line_len`=768 and `frame_lines`=512; `locked`=1 by the 3rd FB; exactly 307200 `pix_valid` pulses per frame.
- **Pixel count and coordinates.**
  - Stimulus: RGB high only for x 100–163, y 448–455 (paddle).
  - Required: `lit_count`=512; first `pix_valid` with RGB≠0 has `pix_x`=100, `pix_y`=448.
- **Loss of lock.** Stimulus: while locked, shorten one line to 700 strobes. Required: `locked` falls on that HSE, with no `frame_done` at the next FB. Relock with `frame_done` after 2 further good FBs.
- **Simultaneous VSE and HSE** on one strobe. Required: FB taken on that strobe and `vcnt`=0; `frame_lines` unchanged versus the nominal frame.
- **Missing h-sync.** Stimulus: hold h-sync high for 2100 strobes. Required: `hcnt` saturates at 2047, `locked`=0, and no `pix_valid` after saturation.
- **Reset mid-frame.** Stimulus: assert `reset` for 3 `clk` at line 200. Required: all outputs 0 asynchronously; relock at the 3rd FB after release.

Source files
------------

// File: rtl/vga_frame_decoder.sv
// rtl/vga_frame_decoder.sv - VGA sync/colour receiver: measures line/frame geometry, locks, recovers pixel coordinates
// and counts lit pixels per frame.
module vga_frame_decoder #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int H_START  = 32,
  parameter int V_START  = 11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_en,
  input  logic        vga_h_sync,
  input  logic        vga_v_sync,
  input  logic        vga_R,
  input  logic        vga_G,
  input  logic        vga_B,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [8:0]  pix_y,
  output logic [2:0]  pix_rgb,
  output logic [10:0] line_len,
  output logic [9:0]  frame_lines,
  output logic        locked,
  output logic        frame_done,
  output logic [18:0] lit_count
);

  localparam logic [10:0] H_LO = 11'(H_START);
  localparam logic [10:0] H_HI = 11'(H_START + H_ACTIVE);
  localparam logic [9:0]  V_LO = 10'(V_START);
  localparam logic [9:0]  V_HI = 10'(V_START + V_ACTIVE);

  typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED} lockState_t;

  lockState_t  state, stateNext;
  logic        hsPrev, vsPrev, vpend;
  logic [10:0] hcnt, refLine;
  logic [9:0]  vcnt, refLines;
  logic [18:0] litAcc;

  logic        hse, vse, fb, active, lit, satHit, match, loadRef;
  logic [10:0] lineMeas;
  logic [9:0]  linesMeas;

  always_comb begin
    hse       = pix_en && !hsPrev && vga_h_sync;
    vse       = pix_en && !vsPrev && vga_v_sync;
    // A v-sync edge landing on the same strobe as the h-sync edge closes the frame immediately.
    fb        = hse && (vpend || vse);
    lineMeas  = hcnt + 11'd1;
    linesMeas = vcnt + 10'd1;
    active    = (hcnt >= H_LO) && (hcnt < H_HI) && (vcnt >= V_LO) && (vcnt < V_HI);
    lit       = active && (vga_R || vga_G || vga_B);
    satHit    = pix_en && !hse && (hcnt >= 11'd2046);
    match     = (lineMeas == refLine) && (linesMeas == refLines);
  end

  always_comb begin
    stateNext = state;
    loadRef   = 1'b0;
    if (hse) begin
      if (state == LOCKED && lineMeas != refLine) stateNext = UNLOCKED;
      if (fb) begin
        case (state)
          UNLOCKED: begin
            stateNext = ACQUIRE;
            loadRef   = 1'b1;
          end
          ACQUIRE: begin
            if (match) stateNext = LOCKED;
            else loadRef = 1'b1;
          end
          LOCKED: begin
            if (!match) stateNext = UNLOCKED;
          end
          default: stateNext = UNLOCKED;
        endcase
      end
    end
    // A line that never ends means the timing source is gone.
    if (satHit) stateNext = UNLOCKED;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= UNLOCKED;
      hsPrev      <= 1'b1;
      vsPrev      <= 1'b1;
      vpend       <= 1'b0;
      hcnt        <= '0;
      vcnt        <= '0;
      refLine     <= '0;
      refLines    <= '0;
      litAcc      <= '0;
      pix_valid   <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_rgb     <= '0;
      line_len    <= '0;
      frame_lines <= '0;
      frame_done  <= 1'b0;
      lit_count   <= '0;
    end else begin
      state      <= stateNext;
      pix_valid  <= pix_en && active && (state == LOCKED);
      frame_done <= fb && (stateNext == LOCKED);
      if (loadRef) begin
        refLine  <= lineMeas;
        refLines <= linesMeas;
      end
      if (pix_en) begin
        hsPrev  <= vga_h_sync;
        vsPrev  <= vga_v_sync;
        pix_x   <= 10'(hcnt - H_LO);
        pix_y   <= 9'(vcnt - V_LO);
        pix_rgb <= {vga_R, vga_G, vga_B};
        if (hse) begin
          line_len <= lineMeas;
          hcnt     <= '0;
        end else if (hcnt != 11'h7FF) begin
          hcnt <= hcnt + 11'd1;
        end
        if (fb) begin
          frame_lines <= linesMeas;
          vcnt        <= '0;
          vpend       <= 1'b0;
          lit_count   <= litAcc;
          litAcc      <= '0;
        end else begin
          if (hse && vcnt != 10'h3FF) vcnt <= vcnt + 10'd1;
          if (vse) vpend <= 1'b1;
          if (lit) litAcc <= litAcc + 19'd1;
        end
      end
    end
  end

  assign locked = (state == LOCKED);

endmodule

// File: tb/tb_vga_frame_decoder.sv
// tb/tb_vga_frame_decoder.sv - self-checking bench for vga_frame_decoder (scaled-down geometry).
module tb_vga_frame_decoder;

  localparam int HA = 16, VA = 8, HS = 4, VS = 2;
  localparam int LL = 28, FL = 14;

  logic        clk, reset, pix_en, vga_h_sync, vga_v_sync, vga_R, vga_G, vga_B;
  logic        pix_valid, locked, frame_done;
  logic [9:0]  pix_x;
  logic [8:0]  pix_y;
  logic [2:0]  pix_rgb;
  logic [10:0] line_len;
  logic [9:0]  frame_lines;
  logic [18:0] lit_count;

  vga_frame_decoder #(.H_ACTIVE(HA), .V_ACTIVE(VA), .H_START(HS), .V_START(VS)) dut (
    .clk(clk), .reset(reset), .pix_en(pix_en), .vga_h_sync(vga_h_sync), .vga_v_sync(vga_v_sync),
    .vga_R(vga_R), .vga_G(vga_G), .vga_B(vga_B), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
    .pix_rgb(pix_rgb), .line_len(line_len), .frame_lines(frame_lines), .locked(locked),
    .frame_done(frame_done), .lit_count(lit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nVec = 0, nMis = 0;
  int validCnt = 0, fdCnt = 0, firstLitX = -1, firstLitY = -1;

  // Reference model: strobe position within line, line within frame, and lock bookkeeping.
  int mPos, mLine, mAcc, mState, refLen, refLines;
  bit mHsPrev, mVsPrev, mVpend;
  bit eValid, eLocked, eFrameDone;
  int eX, eY, eLineLen, eFrameLines, eLit;
  logic [2:0] eRgb;

  typedef struct {
    bit en; bit hs; bit vs;
    int expLen; int expLines; bit expLocked; bit expFd; bit expValid;
  } vec_t;
  vec_t tbl[10];

  task automatic expect_eq(input string name, input longint got, input longint want);
    nVec++;
    if (got != want) begin
      nMis++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic model_reset();
    mPos = 0; mLine = 0; mAcc = 0; mState = 0; refLen = 0; refLines = 0;
    mHsPrev = 1; mVsPrev = 1; mVpend = 0;
    eValid = 0; eLocked = 0; eFrameDone = 0; eX = 0; eY = 0;
    eLineLen = 0; eFrameLines = 0; eLit = 0; eRgb = 3'b000;
  endtask

  task automatic model_strobe(input bit hs, input bit vs, input logic [2:0] rgb);
    bit rise, vrise, boundary, act, same;
    int x, y, newLen, newLines, prev;
    rise     = !mHsPrev && hs;
    vrise    = !mVsPrev && vs;
    boundary = rise && (mVpend || vrise);
    x = mPos - HS;
    y = mLine - VS;
    act = (x >= 0) && (x < HA) && (y >= 0) && (y < VA);
    newLen   = (mPos + 1) % 2048;
    newLines = (mLine + 1) % 1024;
    prev = mState;
    eValid = act && (prev == 2);
    eX = x; eY = y; eRgb = rgb;
    if (rise) eLineLen = newLen;
    if (boundary) begin
      same = (newLen == refLen) && (newLines == refLines);
      if (prev == 0) begin
        mState = 1; refLen = newLen; refLines = newLines;
      end else if (prev == 1) begin
        if (same) mState = 2;
        else begin refLen = newLen; refLines = newLines; end
      end else if (!same) mState = 0;
      eFrameLines = newLines;
      eLit = mAcc;
    end else if (rise && prev == 2 && newLen != refLen) begin
      mState = 0;
    end
    if (!rise && mPos >= 2046) mState = 0;
    eFrameDone = boundary && (mState == 2);
    eLocked = (mState == 2);
    if (rise) mPos = 0;
    else if (mPos < 2047) mPos++;
    if (boundary) begin
      mLine = 0; mVpend = 0; mAcc = 0;
    end else begin
      if (rise && mLine < 1023) mLine++;
      if (vrise) mVpend = 1;
      if (act && rgb != 3'b000) mAcc++;
    end
    mHsPrev = hs; mVsPrev = vs;
  endtask

  task automatic check_outputs();
    nVec++;
    if (pix_valid !== eValid || (eValid && (pix_x !== 10'(eX) || pix_y !== 9'(eY))) ||
        pix_rgb !== eRgb || line_len !== 11'(eLineLen) || frame_lines !== 10'(eFrameLines) ||
        locked !== eLocked || frame_done !== eFrameDone || lit_count !== 19'(eLit)) begin
      nMis++;
      $display("FAIL model t=%0t: got v=%b x=%0d y=%0d rgb=%b len=%0d lines=%0d lk=%b fd=%b lit=%0d; expected v=%b x=%0d y=%0d rgb=%b len=%0d lines=%0d lk=%b fd=%b lit=%0d",
               $time, pix_valid, pix_x, pix_y, pix_rgb, line_len, frame_lines, locked, frame_done, lit_count,
               eValid, eX, eY, eRgb, eLineLen, eFrameLines, eLocked, eFrameDone, eLit);
    end
  endtask

  task automatic cycle(input bit en, input bit hs, input bit vs, input logic [2:0] rgb);
    pix_en = en; vga_h_sync = hs; vga_v_sync = vs; {vga_R, vga_G, vga_B} = rgb;
    if (en) model_strobe(hs, vs, rgb);
    else begin eValid = 0; eFrameDone = 0; end
    @(posedge clk); #1;
    check_outputs();
    if (pix_valid) begin
      validCnt++;
      if (pix_rgb != 3'b000 && firstLitX < 0) begin firstLitX = pix_x; firstLitY = pix_y; end
    end
    if (frame_done) fdCnt++;
  endtask

  task automatic do_reset();
    pix_en = 1'b0;
    #2 reset = 1'b1;
    #1 expect_eq("async_reset_zero",
                 |{pix_valid, pix_x, pix_y, pix_rgb, line_len, frame_lines, locked, frame_done, lit_count}, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
  endtask

  // gap<0 selects random 0..2 idle clocks between strobes.
  task automatic send_frame(input int gap, input int shortLine, input bit simul, input bit paddle, input int resetLine);
    for (int gy = 0; gy < FL; gy++) begin
      int len;
      len = (gy == shortLine) ? 20 : LL;
      for (int gx = 0; gx < len; gx++) begin
        bit hs, vs;
        int x, y, g;
        logic [2:0] rgb;
        hs = !(gx == len - 6 || gx == len - 5);
        vs = simul ? !((gy == 12 && gx >= 24) || (gy == 13 && gx < 24)) : (gy != 12);
        if (gy == resetLine && gx == 10) do_reset();
        x = mPos - HS; y = mLine - VS;
        if (paddle) rgb = (x >= 5 && x <= 8 && y >= 3 && y <= 4) ? 3'b010 : 3'b000;
        else rgb = 3'($urandom);
        g = (gap < 0) ? $urandom_range(0, 2) : gap;
        repeat (g) cycle(1'b0, hs, vs, rgb);
        cycle(1'b1, hs, vs, rgb);
        if (gy == shortLine && gx == len - 4) expect_eq("unlock_on_short_hse", locked, 0);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{0, 1, 1, 0, 0, 0, 0, 0};
    tbl[1] = '{1, 0, 1, 0, 0, 0, 0, 0};
    tbl[2] = '{1, 0, 1, 0, 0, 0, 0, 0};
    tbl[3] = '{0, 1, 1, 0, 0, 0, 0, 0};
    tbl[4] = '{1, 1, 1, 3, 0, 0, 0, 0};
    tbl[5] = '{1, 1, 1, 3, 0, 0, 0, 0};
    tbl[6] = '{1, 0, 0, 3, 0, 0, 0, 0};
    tbl[7] = '{1, 1, 1, 3, 2, 0, 0, 0};
    tbl[8] = '{1, 0, 1, 3, 2, 0, 0, 0};
    tbl[9] = '{1, 1, 1, 2, 2, 0, 0, 0};

    reset = 1'b1; pix_en = 1'b0; vga_h_sync = 1'b1; vga_v_sync = 1'b1;
    {vga_R, vga_G, vga_B} = 3'b000;
    model_reset();
    repeat (2) @(posedge clk);
    #1 expect_eq("reset_zero",
                 |{pix_valid, pix_x, pix_y, pix_rgb, line_len, frame_lines, locked, frame_done, lit_count}, 0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      pix_en = tbl[i].en; vga_h_sync = tbl[i].hs; vga_v_sync = tbl[i].vs;
      @(posedge clk); #1;
      expect_eq($sformatf("tbl%0d_line_len", i), line_len, tbl[i].expLen);
      expect_eq($sformatf("tbl%0d_frame_lines", i), frame_lines, tbl[i].expLines);
      expect_eq($sformatf("tbl%0d_locked", i), locked, tbl[i].expLocked);
      expect_eq($sformatf("tbl%0d_frame_done", i), frame_done, tbl[i].expFd);
      expect_eq($sformatf("tbl%0d_pix_valid", i), pix_valid, tbl[i].expValid);
    end

    do_reset();
    send_frame(3, -1, 0, 1, -1);
    send_frame(3, -1, 0, 1, -1);
    validCnt = 0; firstLitX = -1; firstLitY = -1;
    send_frame(3, -1, 0, 1, -1);
    expect_eq("nominal_line_len", line_len, LL);
    expect_eq("nominal_frame_lines", frame_lines, FL);
    expect_eq("nominal_locked", locked, 1);
    expect_eq("valid_per_frame", validCnt, HA * VA);
    expect_eq("paddle_lit_count", lit_count, 8);
    expect_eq("first_lit_x", firstLitX, 5);
    expect_eq("first_lit_y", firstLitY, 3);

    repeat (3) send_frame(-1, -1, 0, 0, -1);

    fdCnt = 0;
    send_frame(-1, 5, 0, 0, -1);
    expect_eq("short_frame_no_done", fdCnt, 0);
    expect_eq("short_frame_unlocked", locked, 0);
    send_frame(-1, -1, 0, 0, -1);
    expect_eq("relock_done", fdCnt, 1);
    expect_eq("relock_locked", locked, 1);

    fdCnt = 0;
    send_frame(-1, -1, 1, 0, -1);
    expect_eq("simul_frame_lines", frame_lines, FL);
    expect_eq("simul_done", fdCnt, 1);
    send_frame(-1, -1, 0, 0, -1);
    expect_eq("after_simul_frame_lines", frame_lines, FL);

    validCnt = 0;
    repeat (2100) cycle(1'b1, 1'b1, 1'b1, 3'($urandom));
    expect_eq("missing_hsync_unlocked", locked, 0);
    expect_eq("missing_hsync_no_valid", validCnt, 0);
    cycle(1'b1, 1'b0, 1'b1, 3'b000);
    cycle(1'b1, 1'b0, 1'b1, 3'b000);
    cycle(1'b1, 1'b1, 1'b1, 3'b000);
    expect_eq("saturated_line_len_wrap", line_len, 0);
    repeat (3) send_frame(-1, -1, 0, 0, -1);
    expect_eq("relock_after_missing", locked, 1);

    fdCnt = 0;
    send_frame(-1, -1, 0, 0, 7);
    expect_eq("rst_fb1_locked", locked, 0);
    send_frame(-1, -1, 0, 0, -1);
    expect_eq("rst_fb2_locked", locked, 0);
    expect_eq("rst_no_done_yet", fdCnt, 0);
    send_frame(-1, -1, 0, 1, -1);
    expect_eq("rst_fb3_locked", locked, 1);
    expect_eq("rst_fb3_done", fdCnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
